// File: rtl/msrh_fpu_pkg.sv
// Shared FPU types: the IEEE exception-flag bundle carried from the pipes to the CSR.
package msrh_fpu_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int unsigned FFLAGS_W = 5;

endpackage

// File: rtl/bit_cnt.sv
// Population count of a bit vector.
module bit_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]             in,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Ripple sum of set bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(in[i]);
    end
  end

endmodule

// File: rtl/msrh_fflags_entry.sv
// One reservation-station slot: done bit and sticky flags merged from the FPU pipes.
module msrh_fflags_entry
  import msrh_fpu_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    flush,
  input  logic    set,
  input  logic    clear,
  input  fflags_t merge,
  output logic    done,
  output fflags_t fflags,
  output logic    done_next
);

  fflags_t fflags_next;

  // Flush and release win over a same-cycle completion.
  always_comb begin
    done_next   = done;
    fflags_next = fflags;
    if (flush || clear) begin
      done_next   = 1'b0;
      fflags_next = fflags_t'(5'h00);
    end else if (set) begin
      done_next   = 1'b1;
      fflags_next = fflags_t'(fflags | merge);
    end else begin
      done_next   = done;
      fflags_next = fflags;
    end
  end

  // Entry state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      done   <= 1'b0;
      fflags <= fflags_t'(5'h00);
    end else begin
      done   <= done_next;
      fflags <= fflags_next;
    end
  end

endmodule

// File: rtl/msrh_fflags_collector.sv
// Collects per-entry FPU exception flags, commits them in order and keeps sticky fflags.
module msrh_fflags_collector
  import msrh_fpu_pkg::*;
#(
  parameter int unsigned RV_ENTRY_SIZE = 32,
  parameter int unsigned FPU_PIPE_NUM  = 2
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic [FPU_PIPE_NUM-1:0]                     i_done_valid,
  input  logic [FPU_PIPE_NUM-1:0][RV_ENTRY_SIZE-1:0]  i_done_index_oh,
  input  logic [FPU_PIPE_NUM-1:0]                     i_done_fflags_vld,
  input  logic [FPU_PIPE_NUM-1:0][4:0]                i_done_fflags,
  input  logic                                        i_release_valid,
  input  logic [RV_ENTRY_SIZE-1:0]                    i_release_index_oh,
  input  logic                                        i_flush,
  input  logic                                        i_csr_wr_valid,
  input  logic [4:0]                                  i_csr_wr_fflags,
  output logic                                        o_commit_valid,
  output fflags_t                                     o_commit_fflags,
  output logic                                        o_release_err,
  output fflags_t                                     o_fflags_acc,
  output logic [$clog2(RV_ENTRY_SIZE+1)-1:0]          o_pending_cnt
);

  localparam int unsigned CNT_W = $clog2(RV_ENTRY_SIZE + 1);

  logic [RV_ENTRY_SIZE-1:0]    set;
  logic [RV_ENTRY_SIZE-1:0]    rel;
  logic [RV_ENTRY_SIZE-1:0]    done;
  logic [RV_ENTRY_SIZE-1:0]    done_next;
  fflags_t [RV_ENTRY_SIZE-1:0] merge;
  fflags_t [RV_ENTRY_SIZE-1:0] entry_fflags;
  logic                        commit_valid_next;
  logic [4:0]                  commit_fflags_next;
  logic                        release_err_next;
  logic [4:0]                  acc_base;
  logic [4:0]                  acc_add;
  logic [CNT_W-1:0]            pending_next;

  // Decode pipe completions per entry; a flush drops them all.
  always_comb begin
    set   = '0;
    merge = '0;
    rel   = (i_release_valid && !i_flush) ? i_release_index_oh : '0;
    for (int e = 0; e < RV_ENTRY_SIZE; e++) begin
      for (int p = 0; p < FPU_PIPE_NUM; p++) begin
        if (!i_flush && i_done_valid[p] && i_done_index_oh[p][e]) begin
          set[e] = 1'b1;
          if (i_done_fflags_vld[p]) begin
            merge[e] = fflags_t'(merge[e] | i_done_fflags[p]);
          end else begin
            merge[e] = merge[e];
          end
        end else begin
          set[e] = set[e];
        end
      end
    end
  end

  for (genvar g = 0; g < RV_ENTRY_SIZE; g++) begin : g_entry
    msrh_fflags_entry u_entry (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .flush     (i_flush),
      .set       (set[g]),
      .clear     (rel[g]),
      .merge     (merge[g]),
      .done      (done[g]),
      .fflags    (entry_fflags[g]),
      .done_next (done_next[g])
    );
  end

  bit_cnt #(.WIDTH(RV_ENTRY_SIZE)) u_bit_cnt (
    .in  (done_next),
    .cnt (pending_next)
  );

  // Released entries contribute flags if done now or completing this cycle (bypass).
  always_comb begin
    commit_valid_next  = 1'b0;
    commit_fflags_next = 5'h00;
    release_err_next   = 1'b0;
    for (int e = 0; e < RV_ENTRY_SIZE; e++) begin
      if (rel[e]) begin
        if (done[e] || set[e]) begin
          commit_valid_next  = 1'b1;
          commit_fflags_next = commit_fflags_next | entry_fflags[e] | merge[e];
        end else begin
          release_err_next = 1'b1;
        end
      end else begin
        commit_valid_next = commit_valid_next;
      end
    end
  end

  // CSR write replaces the sticky value, a commit in flight is still ORed on top.
  always_comb begin
    acc_base = i_csr_wr_valid ? i_csr_wr_fflags : 5'(o_fflags_acc);
    acc_add  = o_commit_valid ? 5'(o_commit_fflags) : 5'h00;
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_commit_valid  <= 1'b0;
      o_commit_fflags <= fflags_t'(5'h00);
      o_release_err   <= 1'b0;
      o_fflags_acc    <= fflags_t'(5'h00);
      o_pending_cnt   <= '0;
    end else begin
      o_commit_valid  <= commit_valid_next;
      o_commit_fflags <= fflags_t'(commit_fflags_next);
      o_release_err   <= release_err_next;
      o_fflags_acc    <= fflags_t'(acc_base | acc_add);
      o_pending_cnt   <= pending_next;
    end
  end

endmodule

// File: tb/tb_msrh_fflags_collector.sv
// Directed self-checking bench for msrh_fflags_collector.
module tb_msrh_fflags_collector;
  import msrh_fpu_pkg::*;

  localparam int unsigned N = 32;
  localparam int unsigned P = 2;

  logic               i_clk;
  logic               i_reset_n;
  logic [P-1:0]       i_done_valid;
  logic [P-1:0][N-1:0] i_done_index_oh;
  logic [P-1:0]       i_done_fflags_vld;
  logic [P-1:0][4:0]  i_done_fflags;
  logic               i_release_valid;
  logic [N-1:0]       i_release_index_oh;
  logic               i_flush;
  logic               i_csr_wr_valid;
  logic [4:0]         i_csr_wr_fflags;
  logic               o_commit_valid;
  fflags_t            o_commit_fflags;
  logic               o_release_err;
  fflags_t            o_fflags_acc;
  logic [5:0]         o_pending_cnt;

  int total = 0;
  int bad   = 0;

  msrh_fflags_collector #(.RV_ENTRY_SIZE(N), .FPU_PIPE_NUM(P)) dut (
    .i_clk              (i_clk),
    .i_reset_n          (i_reset_n),
    .i_done_valid       (i_done_valid),
    .i_done_index_oh    (i_done_index_oh),
    .i_done_fflags_vld  (i_done_fflags_vld),
    .i_done_fflags      (i_done_fflags),
    .i_release_valid    (i_release_valid),
    .i_release_index_oh (i_release_index_oh),
    .i_flush            (i_flush),
    .i_csr_wr_valid     (i_csr_wr_valid),
    .i_csr_wr_fflags    (i_csr_wr_fflags),
    .o_commit_valid     (o_commit_valid),
    .o_commit_fflags    (o_commit_fflags),
    .o_release_err      (o_release_err),
    .o_fflags_acc       (o_fflags_acc),
    .o_pending_cnt      (o_pending_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic idle();
    i_done_valid       = '0;
    i_done_index_oh    = '0;
    i_done_fflags_vld  = '0;
    i_done_fflags      = '0;
    i_release_valid    = 1'b0;
    i_release_index_oh = '0;
    i_flush            = 1'b0;
    i_csr_wr_valid     = 1'b0;
    i_csr_wr_fflags    = 5'h00;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic done_on(input int p, input int e, input logic [4:0] f);
    i_done_valid[p]       = 1'b1;
    i_done_index_oh[p]    = '0;
    i_done_index_oh[p][e] = 1'b1;
    i_done_fflags_vld[p]  = 1'b1;
    i_done_fflags[p]      = f;
  endtask

  task automatic release_one(input int e);
    i_release_valid       = 1'b1;
    i_release_index_oh    = '0;
    i_release_index_oh[e] = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    i_reset_n = 1'b0;
    step(); step();
    i_reset_n = 1'b1;
    step();
    total++; if (o_commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid got=%b want=0", o_commit_valid); end
    total++; if (o_commit_fflags !== 5'h00) begin bad++; $display("FAIL reset_commit_fflags got=%h want=00", o_commit_fflags); end
    total++; if (o_release_err !== 1'b0) begin bad++; $display("FAIL reset_release_err got=%b want=0", o_release_err); end
    total++; if (o_fflags_acc !== 5'h00) begin bad++; $display("FAIL reset_acc got=%h want=00", o_fflags_acc); end
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", o_pending_cnt); end
  endtask

  task automatic test_single();
    done_on(0, 3, 5'h01);
    step(); idle();
    total++; if (o_pending_cnt !== 6'd1) begin bad++; $display("FAIL single_pending got=%0d want=1", o_pending_cnt); end
    step();
    release_one(3);
    step(); idle();
    total++; if (o_commit_valid !== 1'b1) begin bad++; $display("FAIL single_commit_valid got=%b want=1", o_commit_valid); end
    total++; if (o_commit_fflags !== 5'h01) begin bad++; $display("FAIL single_commit_fflags got=%h want=01", o_commit_fflags); end
    total++; if (o_fflags_acc !== 5'h00) begin bad++; $display("FAIL single_acc_early got=%h want=00", o_fflags_acc); end
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL single_pending_after got=%0d want=0", o_pending_cnt); end
    step();
    total++; if (o_fflags_acc !== 5'h01) begin bad++; $display("FAIL single_acc got=%h want=01", o_fflags_acc); end
    total++; if (o_commit_valid !== 1'b0) begin bad++; $display("FAIL single_commit_pulse got=%b want=0", o_commit_valid); end
  endtask

  task automatic test_dual_pipe();
    done_on(0, 7, 5'h10);
    done_on(1, 7, 5'h04);
    step(); idle();
    total++; if (o_pending_cnt !== 6'd1) begin bad++; $display("FAIL dual_pending got=%0d want=1", o_pending_cnt); end
    release_one(7);
    step(); idle();
    total++; if (o_commit_fflags !== 5'h14) begin bad++; $display("FAIL dual_commit_fflags got=%h want=14", o_commit_fflags); end
    step();
    total++; if (o_fflags_acc !== 5'h15) begin bad++; $display("FAIL dual_acc got=%h want=15", o_fflags_acc); end
  endtask

  task automatic test_bypass();
    done_on(0, 5, 5'h08);
    release_one(5);
    step(); idle();
    total++; if (o_commit_valid !== 1'b1) begin bad++; $display("FAIL bypass_commit_valid got=%b want=1", o_commit_valid); end
    total++; if (o_commit_fflags !== 5'h08) begin bad++; $display("FAIL bypass_commit_fflags got=%h want=08", o_commit_fflags); end
    total++; if (o_release_err !== 1'b0) begin bad++; $display("FAIL bypass_err got=%b want=0", o_release_err); end
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL bypass_pending got=%0d want=0", o_pending_cnt); end
    step();
    total++; if (o_fflags_acc !== 5'h1d) begin bad++; $display("FAIL bypass_acc got=%h want=1d", o_fflags_acc); end
  endtask

  task automatic test_release_err();
    release_one(9);
    step(); idle();
    total++; if (o_release_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b want=1", o_release_err); end
    total++; if (o_commit_valid !== 1'b0) begin bad++; $display("FAIL err_commit_valid got=%b want=0", o_commit_valid); end
    step();
    total++; if (o_release_err !== 1'b0) begin bad++; $display("FAIL err_pulse_end got=%b want=0", o_release_err); end
    total++; if (o_fflags_acc !== 5'h1d) begin bad++; $display("FAIL err_acc got=%h want=1d", o_fflags_acc); end
  endtask

  task automatic test_flush();
    done_on(0, 0, 5'h01);
    done_on(1, 2, 5'h02);
    step(); idle();
    done_on(0, 4, 5'h04);
    step(); idle();
    total++; if (o_pending_cnt !== 6'd3) begin bad++; $display("FAIL flush_pending_before got=%0d want=3", o_pending_cnt); end
    i_flush = 1'b1;
    done_on(0, 1, 5'h10);
    step(); idle();
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL flush_pending got=%0d want=0", o_pending_cnt); end
    total++; if (o_fflags_acc !== 5'h1d) begin bad++; $display("FAIL flush_acc got=%h want=1d", o_fflags_acc); end
    release_one(1);
    step(); idle();
    total++; if (o_release_err !== 1'b1) begin bad++; $display("FAIL flush_dropped_done got=%b want=1", o_release_err); end
    total++; if (o_commit_valid !== 1'b0) begin bad++; $display("FAIL flush_no_commit got=%b want=0", o_commit_valid); end
    step();
  endtask

  task automatic test_csr_write();
    i_csr_wr_valid  = 1'b1;
    i_csr_wr_fflags = 5'h1c;
    step(); idle();
    total++; if (o_fflags_acc !== 5'h1c) begin bad++; $display("FAIL csr_load got=%h want=1c", o_fflags_acc); end
    done_on(0, 3, 5'h01);
    step(); idle();
    release_one(3);
    step(); idle();
    total++; if (o_commit_valid !== 1'b1) begin bad++; $display("FAIL csr_commit_valid got=%b want=1", o_commit_valid); end
    i_csr_wr_valid  = 1'b1;
    i_csr_wr_fflags = 5'h02;
    step(); idle();
    total++; if (o_fflags_acc !== 5'h03) begin bad++; $display("FAIL csr_and_commit got=%h want=03", o_fflags_acc); end
  endtask

  task automatic test_multi_release();
    done_on(0, 10, 5'h08);
    done_on(1, 11, 5'h04);
    step(); idle();
    i_release_valid = 1'b1;
    step(); idle();
    total++; if (o_commit_valid !== 1'b0 || o_release_err !== 1'b0) begin bad++; $display("FAIL empty_release got=%b%b want=00", o_commit_valid, o_release_err); end
    i_release_valid          = 1'b1;
    i_release_index_oh[10]   = 1'b1;
    i_release_index_oh[11]   = 1'b1;
    i_release_index_oh[12]   = 1'b1;
    step(); idle();
    total++; if (o_commit_fflags !== 5'h0c) begin bad++; $display("FAIL multi_commit_fflags got=%h want=0c", o_commit_fflags); end
    total++; if (o_release_err !== 1'b1) begin bad++; $display("FAIL multi_err got=%b want=1", o_release_err); end
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL multi_pending got=%0d want=0", o_pending_cnt); end
    step();
    total++; if (o_fflags_acc !== 5'h0f) begin bad++; $display("FAIL multi_acc got=%h want=0f", o_fflags_acc); end
  endtask

  task automatic test_reset_mid();
    done_on(0, 6, 5'h10);
    step(); idle();
    release_one(6);
    i_reset_n = 1'b0;
    #1;
    total++; if (o_pending_cnt !== 6'd0) begin bad++; $display("FAIL midrst_async got=%0d want=0", o_pending_cnt); end
    step(); idle();
    i_reset_n = 1'b1;
    step();
    total++; if (o_commit_valid !== 1'b0) begin bad++; $display("FAIL midrst_commit got=%b want=0", o_commit_valid); end
    total++; if (o_fflags_acc !== 5'h00) begin bad++; $display("FAIL midrst_acc got=%h want=00", o_fflags_acc); end
    release_one(6);
    step(); idle();
    total++; if (o_release_err !== 1'b1) begin bad++; $display("FAIL midrst_entry_cleared got=%b want=1", o_release_err); end
  endtask

  initial begin
    idle();
    i_reset_n = 1'b0;
    test_reset();
    test_single();
    test_dual_pipe();
    test_bypass();
    test_release_err();
    test_flush();
    test_csr_write();
    test_multi_release();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrh_fflags_collector.md
MSRH_FFLAGS_COLLECTOR -- requirements
Module: msrh_fflags_collector

Interface
REQ-001 Parameter RV_ENTRY_SIZE, default 32, number of FPU reservation-station entries tracked.
REQ-002 Parameter FPU_PIPE_NUM, default 2, number of FPU pipe done ports.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_done_valid  input  [FPU_PIPE_NUM]  per-pipe EX3 done strobe.
REQ-006 i_done_index_oh  input  [FPU_PIPE_NUM][RV_ENTRY_SIZE]  one-hot RS entry completed.
REQ-007 i_done_fflags_vld  input  [FPU_PIPE_NUM]  fflags field is meaningful.
REQ-008 i_done_fflags  input  [FPU_PIPE_NUM][5]  exception flags NV,DZ,OF,UF,NX.
REQ-009 i_release_valid  input  1  in-order commit of RS entries.
REQ-010 i_release_index_oh  input  RV_ENTRY_SIZE  entries released; may be multi-hot.
REQ-011 i_flush  input  1  pipeline flush.
REQ-012 i_csr_wr_valid  input  1  CSR write of fflags/fcsr.
REQ-013 i_csr_wr_fflags  input  5  value written by CSR.
REQ-014 o_commit_valid  output  1  registered commit pulse.
REQ-015 o_commit_fflags  output  5  flags of committed entries.
REQ-016 o_release_err  output  1  registered pulse: released entry not done.
REQ-017 o_fflags_acc  output  5  architectural sticky fflags.
REQ-018 o_pending_cnt  output  $clog2(RV_ENTRY_SIZE+1)  count of done, unreleased entries.

Function
REQ-019 Each entry SHALL hold done bit and 5-bit fflags.
REQ-020 Done on pipe p for entry e SHALL set done[e] and OR (i_done_fflags_vld[p] ? i_done_fflags[p] : 0) into fflags[e] next cycle.
REQ-021 Multiple pipes hitting the same entry in one cycle SHALL OR all their flags.
REQ-022 Release SHALL register o_commit_valid=1 next cycle when any released entry is done, o_commit_fflags = OR of released entries' flags.
REQ-023 Done and release of the same entry in the same cycle SHALL bypass: incoming flags included in commit, entry counts as done.
REQ-024 Release of any not-done entry SHALL pulse o_release_err next cycle; its flags contribute 0.
REQ-025 Released entries SHALL be cleared (done=0, fflags=0) next cycle; done for an entry not being released is unaffected.
REQ-026 All-zero i_release_index_oh with i_release_valid SHALL produce no commit, no error.
REQ-027 i_flush SHALL clear all entries next cycle, drop same-cycle done and release, and not alter o_fflags_acc.
REQ-028 Accumulator next = (i_csr_wr_valid ? i_csr_wr_fflags : acc) | (o_commit_valid ? o_commit_fflags : 0).
REQ-029 Latency: release cycle N -> o_commit_valid cycle N+1 -> o_fflags_acc cycle N+2.
REQ-030 o_pending_cnt SHALL be registered popcount of done bits, reflecting post-update state.

Reset
REQ-031 Reset SHALL clear all entries, o_commit_valid=0, o_commit_fflags=0, o_release_err=0, o_fflags_acc=0, o_pending_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending flags and in-flight commits.

Structure
REQ-033 fflags_t (5-bit packed struct nv,dz,of,uf,nx) SHALL live in msrh_fpu_pkg.
REQ-034 Per-entry storage SHALL be one sub-module msrh_fflags_entry (done, fflags, clear, merge); popcount via existing bit_cnt utility.

Verification
REQ-035 Done pipe0 entry3 fflags=5'h01, release entry3 two cycles later -> o_commit_fflags=5'h01 at N+1, o_fflags_acc=5'h01 at N+2.
REQ-036 Pipe0 and pipe1 done entry7 same cycle, fflags 5'h10 and 5'h04 -> commit 5'h14.
REQ-037 Done and release entry5 same cycle, fflags 5'h08 -> commit 5'h08 next cycle, o_pending_cnt unchanged.
REQ-038 Release entry9 never done -> o_release_err=1, o_commit_valid=0.
REQ-039 Three entries done, i_flush with same-cycle done on entry1 -> o_pending_cnt=0, o_fflags_acc unchanged.
REQ-040 CSR write 5'h02 same cycle as o_commit_valid with 5'h01, acc 5'h1C -> o_fflags_acc=5'h03.
